// File: rtl/fib_sched_pkg.sv
// Shared defaults and types for the FIB lookup scheduler.
package fib_sched_pkg;
  localparam int WORD_SIZE       = 32;
  localparam int MAX_NAME_LENGTH = 8;
  localparam int POINTER_SIZE    = 16;

  typedef logic [MAX_NAME_LENGTH-1:0][WORD_SIZE-1:0] name_t;
  typedef logic [POINTER_SIZE-1:0] ptr_t;

  // Occupancy view of the scheduler, decoded from the in-flight count.
  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_FULL
  } sched_state_e;
endpackage

// File: rtl/fib_id_fifo.sv
// In-order FIFO of requester IDs; one entry per lookup in flight in the FIB pipeline.
module fib_id_fifo #(
  parameter int DEPTH = 8,
  parameter int IDW   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [IDW-1:0]           push_id,
  input  logic                     pop,
  output logic [IDW-1:0]           head_id,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [IDW-1:0] mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           do_push;
  logic           do_pop;

  // Pointers carry one extra bit so full and empty differ without a flag.
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && (count != (AW+1)'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head_id = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_id;
  end
endmodule

// File: rtl/fib_lookup_scheduler.sv
// Round-robin scheduler sharing one FIB lookup pipeline among NUM_REQ requesters.
// Optional watchdog enabled by defining FIB_TIMEOUT_EN.
module fib_lookup_scheduler
  import fib_sched_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int WORD_SIZE       = fib_sched_pkg::WORD_SIZE,
  parameter int MAX_NAME_LENGTH = fib_sched_pkg::MAX_NAME_LENGTH,
  parameter int POINTER_SIZE    = fib_sched_pkg::POINTER_SIZE,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_REQ-1:0]                            req_valid,
  output logic [NUM_REQ-1:0]                            req_ready,
  input  logic [NUM_REQ*MAX_NAME_LENGTH*WORD_SIZE-1:0]  req_name,
  input  logic                                          fib_ready,
  output logic                                          fib_issue,
  output logic [MAX_NAME_LENGTH*WORD_SIZE-1:0]          fib_name_out,
  input  logic                                          fib_result_valid,
  input  logic [POINTER_SIZE-1:0]                       fib_result,
  output logic [NUM_REQ-1:0]                            resp_valid,
  output logic [POINTER_SIZE-1:0]                       resp_ptr,
  output logic [$clog2(MAX_OUTSTANDING):0]              outstanding,
  output logic                                          orphan_err,
  output logic                                          timeout_err
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int NW  = MAX_NAME_LENGTH * WORD_SIZE;
  localparam int CW  = $clog2(MAX_OUTSTANDING) + 1;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  sched_state_e   state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] idx;
  logic [IDW-1:0] head_id;
  logic           gnt_found;
  logic           can_issue;
  logic           pop;

  always_comb begin
    state = S_ACTIVE;
    if (outstanding == '0)                        state = S_IDLE;
    else if (outstanding == CW'(MAX_OUTSTANDING)) state = S_FULL;
  end

  // Handshake: a requester's name transfers in the cycle where req_valid[i] and
  // req_ready[i] are both high; req_ready is a combinational one-hot grant that
  // depends on req_valid, so requesters must not wait on ready before asserting valid.
  assign can_issue = fib_ready && (state != S_FULL);
  assign pop       = fib_result_valid && (state != S_IDLE);

  always_comb begin
    req_ready = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    if (can_issue) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = rr_ptr + IDW'(k);
        if (!gnt_found && req_valid[idx]) begin
          gnt_found = 1'b1;
          gnt_idx   = idx;
        end
      end
      req_ready[gnt_idx] = gnt_found;
    end
  end

  fib_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .IDW   (IDW)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (gnt_found),
    .push_id (gnt_idx),
    .pop     (pop),
    .head_id (head_id),
    .count   (outstanding)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= '0;
      fib_issue    <= 1'b0;
      fib_name_out <= '0;
      resp_valid   <= '0;
      resp_ptr     <= '0;
      orphan_err   <= 1'b0;
    end else begin
      fib_issue <= gnt_found;
      if (gnt_found) begin
        rr_ptr       <= gnt_idx + 1'b1;
        fib_name_out <= req_name[gnt_idx*NW +: NW];
      end
      resp_valid <= pop ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << head_id) : '0;
      if (pop) resp_ptr <= fib_result;
      // A same-cycle grant at empty is not yet visible to the return path.
      if (fib_result_valid && (state == S_IDLE)) orphan_err <= 1'b1;
    end
  end

`ifdef FIB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;
  logic          wd_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
      wd_err <= 1'b0;
    end else if ((state == S_IDLE) || fib_result_valid) begin
      wd_cnt <= '0;
    end else if (wd_cnt != TW'(TIMEOUT_CYCLES)) begin
      wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt + 1'b1 == TW'(TIMEOUT_CYCLES)) wd_err <= 1'b1;
    end
  end
  assign timeout_err = wd_err;
`else
  assign timeout_err = 1'b0;
`endif
endmodule
